// File: rtl/ff_pkg.sv
// Shared definitions for the flip-flop bank: mode encodings used by the
// per-bit cells and the bank top.
package ff_pkg;

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

endpackage

// File: rtl/ff_cell.sv
// Single configurable flip-flop bit (SR/JK/D/T) with a registered change pulse
// and a combinational forbidden-SR strobe.
module ff_cell
    import ff_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       a,
    input  logic       b,
    output logic       q,
    output logic       changed,
    output logic       forbidden
);

    logic q_q;
    logic q_d;
    logic changed_q;

    always_comb begin
        q_d       = q_q;
        forbidden = 1'b0;
        if (en) begin
            unique case (mode)
                MODE_SR: begin
                    // S=R=1 is illegal: hold state and flag it.
                    if (a && b) begin
                        forbidden = 1'b1;
                    end else if (a) begin
                        q_d = 1'b1;
                    end else if (b) begin
                        q_d = 1'b0;
                    end
                end
                MODE_JK: begin
                    if (a && b) begin
                        q_d = ~q_q;
                    end else if (a) begin
                        q_d = 1'b1;
                    end else if (b) begin
                        q_d = 1'b0;
                    end
                end
                MODE_D: begin
                    q_d = a;
                end
                MODE_T: begin
                    q_d = q_q ^ a;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q       <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            changed_q <= q_d ^ q_q;
        end
    end

    assign q       = q_q;
    assign changed = changed_q;

endmodule

// File: rtl/ff_bank.sv
// Bank of WIDTH mode-selectable flip-flops with sticky per-bit forbidden-SR
// flags and a saturating count of cycles containing a forbidden event.
module ff_bank
    import ff_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qnot,
    output logic [WIDTH-1:0] changed,
    output logic [WIDTH-1:0] invalid,
    output logic [CNT_W-1:0] invalid_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] forbidden;
    logic             any_forbidden;
    logic [WIDTH-1:0] invalid_q;
    logic [WIDTH-1:0] invalid_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_cell u_cell (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .mode      (mode),
            .a         (a[i]),
            .b         (b[i]),
            .q         (q[i]),
            .changed   (changed[i]),
            .forbidden (forbidden[i])
        );
    end

    assign any_forbidden = |forbidden;

    always_comb begin
        invalid_d = invalid_q | forbidden;
        cnt_d     = cnt_q;
        if (clr_flags) begin
            // A fresh event on the clearing edge survives the clear.
            invalid_d = forbidden;
            cnt_d     = any_forbidden ? CNT_W'(1) : '0;
        end else if (any_forbidden && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            invalid_q <= '0;
            cnt_q     <= '0;
        end else begin
            invalid_q <= invalid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign qnot        = ~q;
    assign invalid     = invalid_q;
    assign invalid_cnt = cnt_q;

endmodule

// File: tb/tb_ff_bank.sv
// Scoreboard bench for ff_bank: each step predicts the post-edge outputs with a
// behavioural model, queues them, and the scenario tasks pop and compare.
module tb_ff_bank;

    localparam int W = 8;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         clr_flags;
    logic [W-1:0] q;
    logic [W-1:0] qnot;
    logic [W-1:0] changed;
    logic [W-1:0] invalid;
    logic [C-1:0] invalid_cnt;

    ff_bank #(.WIDTH(W), .CNT_W(C)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .a           (a),
        .b           (b),
        .clr_flags   (clr_flags),
        .q           (q),
        .qnot        (qnot),
        .changed     (changed),
        .invalid     (invalid),
        .invalid_cnt (invalid_cnt)
    );

    always #5 clk = ~clk;

    // {q, qnot, changed, invalid, invalid_cnt}
    logic [4*W+C-1:0] obs;
    assign obs = {q, qnot, changed, invalid, invalid_cnt};

    logic [4*W+C-1:0] sb[$];
    logic [4*W+C-1:0] exp_v;

    int total = 0;
    int bad   = 0;

    // Bench model state
    logic [W-1:0] m_q   = '0;
    logic [W-1:0] m_inv = '0;
    logic [C-1:0] m_cnt = '0;

    task automatic step(input logic r, input logic e, input logic [1:0] md,
                        input logic [W-1:0] av, input logic [W-1:0] bv, input logic clr);
        logic [W-1:0] nq;
        logic [W-1:0] forb;
        logic [W-1:0] chg;
        rst = r; en = e; mode = md; a = av; b = bv; clr_flags = clr;
        nq   = m_q;
        forb = '0;
        for (int i = 0; i < W; i++) begin
            if (md == 2'b00) begin
                if (av[i] && bv[i]) forb[i] = 1'b1;
                else if (av[i]) nq[i] = 1'b1;
                else if (bv[i]) nq[i] = 1'b0;
            end else if (md == 2'b01) begin
                if (av[i] && bv[i]) nq[i] = ~m_q[i];
                else if (av[i]) nq[i] = 1'b1;
                else if (bv[i]) nq[i] = 1'b0;
            end else if (md == 2'b10) begin
                nq[i] = av[i];
            end else if (av[i]) begin
                nq[i] = ~m_q[i];
            end
        end
        if (!e) begin
            nq   = m_q;
            forb = '0;
        end
        chg = nq ^ m_q;
        if (r) begin
            m_q = '0; chg = '0; m_inv = '0; m_cnt = '0;
        end else begin
            m_q = nq;
            if (clr) begin
                m_inv = forb;
                m_cnt = (forb != 0) ? C'(1) : C'(0);
            end else begin
                m_inv = m_inv | forb;
                if ((forb != 0) && (m_cnt != {C{1'b1}})) m_cnt = m_cnt + C'(1);
            end
        end
        sb.push_back({m_q, ~m_q, chg, m_inv, m_cnt});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 2'b10, 8'hFF, 8'h00, 1'b1);
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL reset edge %0d: got %h want %h", i, obs, exp_v);
            end
        end
        total++;
        if ({q, qnot, invalid_cnt} !== {8'h00, 8'hFF, 4'h0}) begin
            bad++;
            $display("FAIL reset_const: got q=%h qnot=%h cnt=%h want 00 ff 0", q, qnot, invalid_cnt);
        end
    endtask

    task automatic test_sr_sweep();
        logic [W-1:0] ta[4]   = '{8'h00, 8'h00, 8'hFF, 8'hFF};
        logic [W-1:0] tb[4]   = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        logic [W-1:0] tq[4]   = '{8'h00, 8'h00, 8'hFF, 8'hFF};
        logic [W-1:0] tchg[4] = '{8'h00, 8'h00, 8'hFF, 8'h00};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 2'b00, ta[i], tb[i], 1'b0);
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL sr_sweep step %0d: got %h want %h", i, obs, exp_v);
            end
            total++;
            if ({q, changed} !== {tq[i], tchg[i]}) begin
                bad++;
                $display("FAIL sr_plan step %0d: got q=%h chg=%h want %h %h",
                         i, q, changed, tq[i], tchg[i]);
            end
        end
        total++;
        if ({invalid, invalid_cnt} !== {8'hFF, 4'h1}) begin
            bad++;
            $display("FAIL sr_invalid: got %h/%h want ff/1", invalid, invalid_cnt);
        end
    endtask

    task automatic test_jk_toggle();
        logic [W-1:0] tq[3] = '{8'h0F, 8'h00, 8'h0F};
        step(1'b0, 1'b1, 2'b10, 8'h00, 8'h00, 1'b1);  // q=00, flags cleared
        exp_v = sb.pop_front();
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL jk_setup: got %h want %h", obs, exp_v);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 2'b01, 8'h0F, 8'h0F, 1'b0);
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v || q !== tq[i] || changed !== 8'h0F || invalid !== 8'h00) begin
                bad++;
                $display("FAIL jk_toggle step %0d: got %h want %h (q plan %h)", i, obs, exp_v, tq[i]);
            end
        end
    endtask

    task automatic test_d_t_enable();
        logic         te[3] = '{1'b1, 1'b0, 1'b1};
        logic [1:0]   tm[3] = '{2'b10, 2'b10, 2'b11};
        logic [W-1:0] ta[3] = '{8'hA5, 8'h5A, 8'hFF};
        logic [W-1:0] tq[3] = '{8'hA5, 8'hA5, 8'h5A};
        for (int i = 0; i < 3; i++) begin
            step(1'b0, te[i], tm[i], ta[i], 8'hFF, 1'b0);
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v || q !== tq[i]) begin
                bad++;
                $display("FAIL d_t_enable step %0d: got %h want %h (q plan %h)", i, obs, exp_v, tq[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic q0;
        step(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
        exp_v = sb.pop_front();
        q0 = q[0];
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 2'b00, 8'h01, 8'h01, 1'b0);
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL saturation step %0d: got %h want %h", i, obs, exp_v);
            end
        end
        total++;
        if (invalid_cnt !== 4'hF || invalid !== 8'h01 || q[0] !== q0) begin
            bad++;
            $display("FAIL sat_final: got cnt=%h inv=%h q0=%b want f 01 %b", invalid_cnt, invalid, q[0], q0);
        end
    endtask

    task automatic test_clear_priority();
        step(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
        exp_v = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0);
            exp_v = sb.pop_front();
        end
        total++;
        if ({invalid, invalid_cnt} !== {8'hFF, 4'h5}) begin
            bad++;
            $display("FAIL clr_setup: got %h/%h want ff/5", invalid, invalid_cnt);
        end
        step(1'b0, 1'b1, 2'b00, 8'h02, 8'h02, 1'b1);
        exp_v = sb.pop_front();
        total++;
        if (obs !== exp_v || {invalid, invalid_cnt} !== {8'h02, 4'h1}) begin
            bad++;
            $display("FAIL clr_with_event: got %h want %h", obs, exp_v);
        end
        step(1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b1);
        exp_v = sb.pop_front();
        total++;
        if (obs !== exp_v || {invalid, invalid_cnt} !== {8'h00, 4'h0}) begin
            bad++;
            $display("FAIL clr_alone: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1, 2'b10, 8'hFF, 8'h00, 1'b1);
        exp_v = sb.pop_front();
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0);
            exp_v = sb.pop_front();
        end
        total++;
        if ({q, invalid, invalid_cnt} !== {8'hFF, 8'hFF, 4'h7}) begin
            bad++;
            $display("FAIL rst_mid_setup: got q=%h inv=%h cnt=%h want ff ff 7", q, invalid, invalid_cnt);
        end
        step(1'b1, 1'b1, 2'b10, 8'hFF, 8'h00, 1'b0);
        exp_v = sb.pop_front();
        total++;
        if (obs !== exp_v || obs !== {8'h00, 8'hFF, 8'h00, 8'h00, 4'h0}) begin
            bad++;
            $display("FAIL rst_mid: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b1, 2'b10, 8'h00, 8'h00, 1'b1);
        exp_v = sb.pop_front();
        for (int i = 0; i < 60; i++) begin
            step(1'b0, ($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                 W'($urandom), W'($urandom), ($urandom_range(0, 9) == 0));
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL back_to_back step %0d: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; a = '0; b = '0; clr_flags = 1'b0;
        #1;
        test_reset();
        test_sr_sweep();
        test_jk_toggle();
        test_d_t_enable();
        test_saturation();
        test_clear_priority();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
